scope_overlay_mc: RTL and testbench
===================================

Name: scope_overlay_mc

Overview:
- Parametrised multi-channel audio-scope overlay. Keeps a per-frame history of audio samples for each channel and draws it over the video as bars or dots.
- Sits beside the video output path. Its colour output is ORed or muxed into the RGB stream by the top level.
- Everything runs on clk_vid. Syncs are edge-detected in that domain; no sync signal is used as a clock.

Parameters:
- DW, 8, bits per channel sample.
- CHANNELS, 2, number of audio channels (1..4).
- DEPTH, 32, history entries per channel (2..64; need not be a power of two).
- COL_SHIFT, 4, log2 of pixels per history column.
- X_OFFSET, 11, column index of the leftmost history entry.
- Y_BASE, 480, baseline line number.
- HCW, 13, pixel counter width.
- VCW, 10, line counter width.

Ports:
- clk_vid  in  1  video clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  CHANNELS*DW  packed samples; channel c is din[c*DW +: DW].
- sample  in  1  strobe that latches din into the hold register.
- hsync  in  1  horizontal sync, low during sync.
- vsync  in  1  vertical sync, low during sync.
- en  in  1  overlay enable.
- mode  in  2  0=off, 1=bars, 2=dots, 3=frozen bars.
- color  out  8  overlay colour; 0 = transparent.
- active  out  1  high when color is non-zero.

Behaviour:
- Reset: asynchronous, active-high. Clears hold, all history entries, wptr, hcount, vcount, sync delay registers, color (to 8'h00) and active (to 0).
- Sync edges:
  - hs_d and vs_d are registered copies of hsync and vsync.
  - hs_rise = hsync & ~hs_d; vs_rise = vsync & ~vs_d.
- hcount:
  - Increments by 1 each clock.
  - Forced to 0 while hsync is low.
  - Wraps naturally at 2^HCW.
- vcount:
  - Increments by 1 on each hs_rise.
  - Forced to 0 while vsync is low; this takes priority over the increment.
- Hold register: when sample=1, hold <= din. Otherwise hold is unchanged.
- History push:
  - Happens on vs_rise when mode != 3.
  - Every channel's hold value is written to history[c][wptr].
  - wptr <= (wptr == DEPTH-1) ? 0 : wptr+1.
  - sample and vs_rise in the same cycle: the pre-update hold value is pushed. The new value is pushed on the next frame.
  - mode 3: no push and wptr is frozen. Display continues from the frozen contents.
  - Pushes continue when en=0 or mode=0.
- Column mapping:
  - col = hcount >> COL_SHIFT; idx = col - X_OFFSET, computed signed.
  - The column is valid only when 0 <= idx < DEPTH.
  - idx 0 is the newest entry, history[(wptr-1) mod DEPTH]. idx k is entry (wptr-1-k) mod DEPTH, modulo arithmetic correct for non-power-of-2 DEPTH.
- Height: h = s >> (DW-7), i.e. the top 7 bits of the sample, range 0..127. top = Y_BASE - h.
- Lit conditions, per channel, evaluated only for a valid column:
  - Bars (modes 1 and 3): top < vcount <= Y_BASE.
  - Dots (mode 2): vcount == top and h != 0.
- Channel colours: ch0=8'h80, ch1=8'h1C, ch2=8'hE0, ch3=8'h03.
- Overlap: the lowest-index lit channel wins.
- Output:
  - color = (en && mode != 0 && any channel lit) ? winning colour : 8'h00.
  - active = (color != 0).
  - Both are registered: one clk_vid of latency relative to the hcount/vcount values used.
- Reset mid-frame: counters restart from 0, the history is empty and the output stays 0 until conditions are met again.

Test Plan:
- Reset, then mode=1, en=1, no samples, run 2 frames -> color stays 8'h00 and active stays 0 everywhere. A sample of 0 draws nothing.
- CHANNELS=2, pulse sample with ch0=8'hFF and ch1=8'h00, then one vsync rise -> ch0 gets h=127.
  - Next frame, column idx 0 (hcount 176..191) on lines 354..480 gives color 8'h80.
  - Line 353 gives 8'h00.
  - ch1 draws nothing.
- Same data in mode=2 -> only line 353 in columns 176..191 is 8'h80; every other line in that column is 0.
- Push 33 frames of ramp values 1..33 with DEPTH=32 -> idx 0 shows 33 and idx 31 shows 2. Value 1 is overwritten and wptr wraps to 1. Repeat the check with DEPTH=24.
- sample and vs_rise in the same cycle, old hold=8'h40, new din=8'h20 -> 8'h40 is pushed this frame and 8'h20 on the next vsync.
- mode=3 across 3 vsyncs with a changing din -> the display is unchanged and wptr is constant.
- en=0 -> color is 0, but the history still advances (checked after en returns to 1).

Source files
------------

// File: rtl/scope_overlay_mc.sv
// scope_overlay_mc: multi-channel audio-scope overlay.
// Keeps one history entry per channel per video frame and draws the history as
// vertical bars or single dots beside the video path. Everything runs on clk_vid;
// hsync/vsync are only edge-detected, never used as clocks.
module scope_overlay_mc #(
    parameter int DW        = 8,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 32,
    parameter int COL_SHIFT = 4,
    parameter int X_OFFSET  = 11,
    parameter int Y_BASE    = 480,
    parameter int HCW       = 13,
    parameter int VCW       = 10
) (
    input  logic                   clk_vid,
    input  logic                   reset,
    input  logic [CHANNELS*DW-1:0] din,
    input  logic                   sample,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   en,
    input  logic [1:0]             mode,
    output logic [7:0]             color,
    output logic                   active
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Column index is computed signed, two bits wider than the pixel counter
    localparam int IW = HCW + 2;
    localparam logic signed [IW-1:0] XOFF_S  = IW'(X_OFFSET);
    localparam logic signed [IW-1:0] DEPTH_S = IW'(DEPTH);

    logic                   hs_d_q, vs_d_q;
    logic [HCW-1:0]         hcount_q, hcount_d;
    logic [VCW-1:0]         vcount_q, vcount_d;
    logic [CHANNELS*DW-1:0] hold_q, hold_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [DW-1:0]          hist_q [CHANNELS][DEPTH];
    logic [7:0]             color_q, color_d;
    logic                   active_q, active_d;

    logic                   hs_rise, vs_rise, push;
    logic signed [IW-1:0]   idx;
    logic                   col_valid;
    logic [PW-1:0]          rd_ptr;
    logic [CHANNELS-1:0]    lit;

    // Bar height is the top 7 bits of the sample (0..127)
    function automatic logic [6:0] height_f(input logic [DW-1:0] s);
        return 7'(s >> (DW - 7));
    endfunction

    // Bars fill (top, Y_BASE]; a dot sits exactly on top and needs a non-zero height
    function automatic logic lit_f(input logic [6:0] h, input logic [VCW-1:0] v,
                                   input logic dots);
        int top;
        int vi;
        top = Y_BASE - int'(h);
        vi  = int'(v);
        if (dots)
            return (vi == top) && (h != 7'd0);
        return (vi > top) && (vi <= Y_BASE);
    endfunction

    // History slot holding the k-th newest entry: (wp - 1 - k) mod DEPTH,
    // written without a power-of-two mask so any DEPTH works
    function automatic logic [PW-1:0] entry_f(input logic [PW-1:0] wp,
                                              input logic signed [IW-1:0] k);
        int t;
        t = int'(wp) + DEPTH - 1 - int'(k);
        if (t >= DEPTH)
            t = t - DEPTH;
        return PW'(t);
    endfunction

    function automatic logic [7:0] chan_color_f(input int c);
        case (c)
            0:       return 8'h80;
            1:       return 8'h1C;
            2:       return 8'hE0;
            default: return 8'h03;
        endcase
    endfunction

    // Sync edges, raster counters, hold register and write-pointer next state
    always_comb begin
        hs_rise  = hsync & ~hs_d_q;
        vs_rise  = vsync & ~vs_d_q;
        push     = vs_rise && (mode != 2'd3);
        hcount_d = hsync ? hcount_q + 1'b1 : '0;
        vcount_d = vcount_q;
        if (!vsync)
            vcount_d = '0;
        else if (hs_rise)
            vcount_d = vcount_q + 1'b1;
        hold_d = sample ? din : hold_q;
        wptr_d = wptr_q;
        if (push)
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end

    // Map the current pixel to a history column and pick the winning channel colour
    always_comb begin
        idx       = $signed({2'b00, hcount_q >> COL_SHIFT}) - XOFF_S;
        col_valid = !idx[IW-1] && (idx < DEPTH_S);
        rd_ptr    = entry_f(wptr_q, idx);
        lit       = '0;
        color_d   = 8'h00;
        for (int c = 0; c < CHANNELS; c++)
            lit[c] = lit_f(height_f(hist_q[c][rd_ptr]), vcount_q, mode == 2'd2);
        if (en && (mode != 2'd0) && col_valid)
            for (int c = CHANNELS - 1; c >= 0; c--)
                if (lit[c])
                    color_d = chan_color_f(c);
        active_d = (color_d != 8'h00);
    end

    // Control and output registers
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            hs_d_q   <= 1'b0;
            vs_d_q   <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hold_q   <= '0;
            wptr_q   <= '0;
            color_q  <= 8'h00;
            active_q <= 1'b0;
        end else begin
            hs_d_q   <= hsync;
            vs_d_q   <= vsync;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hold_q   <= hold_d;
            wptr_q   <= wptr_d;
            color_q  <= color_d;
            active_q <= active_d;
        end
    end

    // Per-frame history: the pre-update hold value of every channel lands at wptr
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int d = 0; d < DEPTH; d++)
                    hist_q[c][d] <= '0;
        end else if (push) begin
            for (int c = 0; c < CHANNELS; c++)
                hist_q[c][wptr_q] <= hold_q[c*DW +: DW];
        end
    end

    assign color  = color_q;
    assign active = active_q;

endmodule

// File: tb/tb_scope_overlay_mc.sv
// Bench for scope_overlay_mc: two instances (DEPTH 32 and 24) share all inputs and
// are compared every cycle against a frame-history model plus directed probes.
module tb_scope_overlay_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = '0;
    logic        sample = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  color_a, color_b;
    logic        active_a, active_b;

    always #5 clk = ~clk;

    scope_overlay_mc dut_a (
        .clk_vid(clk), .reset(reset), .din(din), .sample(sample), .hsync(hsync),
        .vsync(vsync), .en(en), .mode(mode), .color(color_a), .active(active_a)
    );

    scope_overlay_mc #(.DEPTH(24)) dut_b (
        .clk_vid(clk), .reset(reset), .din(din), .sample(sample), .hsync(hsync),
        .vsync(vsync), .en(en), .mode(mode), .color(color_b), .active(active_b)
    );

    // Model state: raster position, hold value and the full list of pushed frames
    int          mh, mv;
    bit          hs_p, vs_p;
    logic [15:0] m_hold;
    logic [15:0] pushes[$];

    int total = 0;
    int bad   = 0;
    int rnd_line;
    bit rs = 1'b0;

    int         n_probes = 0;
    int         pr_v[8], pr_h[8], pr_d[8];
    logic [7:0] pr_exp[8], pr_got[8];

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h line=%0d px=%0d", tag, got, exp, mv, mh);
        end
    endtask

    // Expected overlay colour for a pixel, from the newest-first frame history
    function automatic logic [7:0] model_color(input int depth, input int hc, input int vc);
        int          idx, h, top;
        logic [15:0] e;
        logic [7:0]  s;
        idx = (hc / 16) - 11;
        if (!en || mode == 2'd0 || idx < 0 || idx >= depth)
            return 8'h00;
        e = (idx < pushes.size()) ? pushes[pushes.size() - 1 - idx] : 16'h0000;
        for (int c = 0; c < 2; c++) begin
            s   = (c == 0) ? e[7:0] : e[15:8];
            h   = int'(s) / 2;
            top = 480 - h;
            if ((mode == 2'd2) ? (vc == top && h != 0) : (vc > top && vc <= 480))
                return (c == 0) ? 8'h80 : 8'h1C;
        end
        return 8'h00;
    endfunction

    task automatic tick();
        logic [7:0] ea, eb;
        int         pv, ph;
        bit         vr, hr;
        ea = model_color(32, mh, mv);
        eb = model_color(24, mh, mv);
        pv = mv;
        ph = mh;
        @(posedge clk);
        vr = vsync && !vs_p;
        hr = hsync && !hs_p;
        if (vr && mode != 2'd3)
            pushes.push_back(m_hold);
        if (sample)
            m_hold = din;
        mh   = hsync ? (mh + 1) % 8192 : 0;
        mv   = !vsync ? 0 : (hr ? (mv + 1) % 1024 : mv);
        hs_p = hsync;
        vs_p = vsync;
        #1;
        check8("color_d32", color_a, ea);
        check8("active_d32", {7'b0, active_a}, {7'b0, ea != 8'h00});
        check8("color_d24", color_b, eb);
        check8("active_d24", {7'b0, active_b}, {7'b0, eb != 8'h00});
        for (int i = 0; i < n_probes; i++)
            if (pr_v[i] == pv && pr_h[i] == ph)
                pr_got[i] = (pr_d[i] == 0) ? color_a : color_b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check8("rst_color_d32", color_a, 8'h00);
        check8("rst_active_d32", {7'b0, active_a}, 8'h00);
        check8("rst_color_d24", color_b, 8'h00);
        check8("rst_active_d24", {7'b0, active_b}, 8'h00);
        pushes.delete();
        m_hold = '0;
        mh = 0; mv = 0; hs_p = 1'b0; vs_p = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_probe(input int v, input int h, input int d, input logic [7:0] exp);
        pr_v[n_probes]   = v;
        pr_h[n_probes]   = h;
        pr_d[n_probes]   = d;
        pr_exp[n_probes] = exp;
        pr_got[n_probes] = 8'hxx;
        n_probes++;
    endtask

    task automatic check_probes();
        for (int i = 0; i < n_probes; i++)
            check8($sformatf("probe_d%0d_line%0d_px%0d", (pr_d[i] == 0) ? 32 : 24,
                             pr_v[i], pr_h[i]), pr_got[i], pr_exp[i]);
        n_probes = 0;
    endtask

    task automatic vsync_rise();
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic line(input int len);
        hsync = 1'b0;
        if (rs && $urandom_range(0, 7) == 0) begin
            din    = 16'($urandom);
            sample = 1'b1;
        end
        tick();
        sample = 1'b0;
        hsync  = 1'b1;
        repeat (len) tick();
    endtask

    function automatic bit is_long(input int v);
        return v == 353 || v == 354 || v == 400 || v == 464 || v == 465 ||
               v == 479 || v == 480 || v == rnd_line;
    endfunction

    task automatic frame_full();
        rnd_line = $urandom_range(355, 478);
        vsync_rise();
        for (int v = 1; v <= 481; v++)
            line(is_long(v) ? 700 : 1);
    endtask

    task automatic pulse_sample(input logic [15:0] d);
        din    = d;
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Empty history: nothing drawn over two frames
        mode = 2'd1;
        en   = 1'b1;
        vsync_rise();
        set_probe(400, 180, 0, 8'h00);
        set_probe(480, 680, 0, 8'h00);
        set_probe(480, 180, 1, 8'h00);
        frame_full();
        check_probes();

        // ch0 full scale, ch1 zero: bar in the newest column
        pulse_sample(16'h00FF);
        set_probe(354, 176, 0, 8'h80);
        set_probe(480, 191, 0, 8'h80);
        set_probe(353, 180, 0, 8'h00);
        set_probe(400, 180, 1, 8'h80);
        frame_full();
        check_probes();

        // Dots: only the top line is lit
        mode = 2'd2;
        set_probe(353, 180, 0, 8'h80);
        set_probe(354, 180, 0, 8'h00);
        set_probe(400, 180, 0, 8'h00);
        set_probe(480, 180, 0, 8'h00);
        set_probe(353, 200, 0, 8'h80);
        frame_full();
        check_probes();

        // Ramp 1..33, then freeze across three vsyncs with changing din
        do_reset();
        mode = 2'd1;
        for (int v = 1; v <= 33; v++) begin
            pulse_sample({8'(v), 8'(v)});
            vsync_rise();
        end
        mode = 2'd3;
        repeat (2) begin
            pulse_sample(16'($urandom));
            vsync_rise();
        end
        set_probe(465, 180, 0, 8'h80);
        set_probe(464, 180, 0, 8'h00);
        set_probe(480, 680, 0, 8'h80);
        set_probe(479, 680, 0, 8'h00);
        set_probe(479, 550, 1, 8'h80);
        set_probe(480, 680, 1, 8'h00);
        frame_full();
        check_probes();

        // Sample and vsync rise on the same edge: old hold is pushed first
        mode = 2'd1;
        pulse_sample(16'h4040);
        vsync = 1'b0;
        tick();
        tick();
        vsync  = 1'b1;
        din    = 16'h2020;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        set_probe(465, 180, 0, 8'h80);
        set_probe(464, 180, 0, 8'h00);
        set_probe(464, 200, 0, 8'h80);
        set_probe(400, 200, 0, 8'h00);
        frame_full();
        check_probes();

        // Overlay disabled: blank output while the history keeps advancing
        en = 1'b0;
        set_probe(480, 180, 0, 8'h00);
        set_probe(465, 180, 0, 8'h00);
        frame_full();
        check_probes();
        pulse_sample(16'hFEFE);
        vsync_rise();
        en   = 1'b1;
        mode = 2'd3;
        set_probe(354, 180, 0, 8'h80);
        set_probe(353, 180, 0, 8'h00);
        set_probe(465, 200, 0, 8'h80);
        set_probe(464, 200, 0, 8'h00);
        frame_full();
        check_probes();

        // Random modes, enables and samples, including samples mid-frame
        rs = 1'b1;
        for (int r = 0; r < 2; r++) begin
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 5)) begin
                pulse_sample(16'($urandom));
                vsync_rise();
            end
            frame_full();
        end
        rs = 1'b0;

        // Reset in the middle of a lit bar
        mode = 2'd1;
        en   = 1'b1;
        pulse_sample(16'hFEFE);
        vsync_rise();
        for (int v = 1; v < 400; v++)
            line(1);
        hsync = 1'b0;
        tick();
        hsync = 1'b1;
        repeat (180) tick();
        check8("midframe_lit", color_a, 8'h80);
        do_reset();
        set_probe(400, 180, 0, 8'h00);
        set_probe(354, 180, 0, 8'h00);
        frame_full();
        check_probes();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
